// File: rtl/mux_scan_nto1.sv
// Registered N:1 data selector with active-low enable and channel reporting.
// Define MUX_AUTO_SCAN_EN to build the auto-scan sequencer (dwell counter, wrap pulse).
module mux_scan_nto1 #(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DWELL    = 4,
    localparam int unsigned SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_n,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [SW-1:0]             sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          y,
    output logic [SW-1:0]             ch,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [SW-1:0] LAST_CH = SW'(CHANNELS - 1);

    // Channel k of the packed bus; out-of-range indices read as zero.
    function automatic logic [WIDTH-1:0] pick(input logic [SW-1:0] idx,
                                              input logic [CHANNELS*WIDTH-1:0] d);
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SW'(k)) pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    logic [WIDTH-1:0] y_nxt;
    logic [SW-1:0]    ch_nxt;
    logic             valid_nxt;

`ifdef MUX_AUTO_SCAN_EN
    localparam int unsigned  DW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST_CNT = DW'(DWELL - 1);

    // ST_SCAN doubles as the scan-armed flag.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic          wrap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            ch    <= ch_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        y_nxt     = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        if (en_n) begin
            state_nxt = ST_IDLE;
        end else if (mode) begin
            if (state == ST_IDLE) begin
                state_nxt = ST_SCAN;
                cnt_nxt   = '0;
                ch_nxt    = '0;
            end else if (cnt == LAST_CNT) begin
                cnt_nxt = '0;
                if (ch == LAST_CH) begin
                    ch_nxt   = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    ch_nxt = ch + SW'(1);
                end
            end else begin
                cnt_nxt = cnt + DW'(1);
            end
            y_nxt     = pick(ch_nxt, data);
            valid_nxt = 1'b1;
        end else begin
            // Manual select discards any dwell in progress.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            ch_nxt    = sel;
            y_nxt     = pick(sel, data);
            valid_nxt = (32'(sel) < CHANNELS);
        end
    end
`else
    localparam int unsigned unused_dwell = DWELL;
    logic unused_mode;
    assign unused_mode = mode;
    assign wrap        = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
        end else begin
            y     <= y_nxt;
            ch    <= ch_nxt;
            valid <= valid_nxt;
        end
    end

    always_comb begin
        ch_nxt    = ch;
        y_nxt     = '0;
        valid_nxt = 1'b0;
        if (!en_n) begin
            ch_nxt    = sel;
            y_nxt     = pick(sel, data);
            valid_nxt = (32'(sel) < CHANNELS);
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench for mux_scan_nto1: directed test-plan sequences plus random traffic
// against a cycle-index reference model; follows MUX_AUTO_SCAN_EN like the design.
module tb_mux_scan_nto1;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int DWELL    = 3;
    localparam int SW       = $clog2(CHANNELS);
`ifdef MUX_AUTO_SCAN_EN
    localparam bit SCAN_BUILT = 1'b1;
`else
    localparam bit SCAN_BUILT = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [SW-1:0]    ch;
        logic             valid;
        logic             wrap;
        string            tag;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic                      en_n;
    logic [CHANNELS*WIDTH-1:0] data;
    logic [SW-1:0]             sel;
    logic                      mode;
    logic [WIDTH-1:0]          y;
    logic [SW-1:0]             ch;
    logic                      valid;
    logic                      wrap;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference model: scan position is a plain cycle index since scan entry.
    int m_ch   = 0;
    bit m_scan = 0;
    int m_t    = 0;

    mux_scan_nto1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .data(data), .sel(sel), .mode(mode),
        .y(y), .ch(ch), .valid(valid), .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model_step(input string tag);
        exp_t e;
        int   c;
        e.tag = tag; e.y = '0; e.ch = SW'(m_ch); e.valid = 1'b0; e.wrap = 1'b0;
        if (!rst_n) begin
            m_ch = 0; m_scan = 0; m_t = 0;
            e.ch = '0;
        end else if (en_n) begin
            m_scan = 0;
        end else if (mode && SCAN_BUILT) begin
            if (!m_scan) begin m_scan = 1; m_t = 0; end
            else m_t++;
            c       = (m_t / DWELL) % CHANNELS;
            m_ch    = c;
            e.ch    = SW'(c);
            e.y     = data[c*WIDTH +: WIDTH];
            e.valid = 1'b1;
            e.wrap  = (m_t > 0) && (m_t % (CHANNELS * DWELL) == 0);
        end else begin
            m_scan  = 0;
            m_ch    = int'(sel);
            e.ch    = sel;
            e.valid = (int'(sel) < CHANNELS);
            if (e.valid) e.y = data[int'(sel)*WIDTH +: WIDTH];
        end
        return e;
    endfunction

    // Drive one cycle's inputs away from the edge and log the expected response.
    task automatic cyc(input logic r, input logic e, input logic m, input logic [SW-1:0] s,
                       input logic [CHANNELS*WIDTH-1:0] d, input string tag);
        @(negedge clk);
        rst_n = r; en_n = e; mode = m; sel = s; data = d;
        sb.push_back(model_step(tag));
    endtask

    task automatic check_now(input string tag, input logic [WIDTH-1:0] ey, input logic [SW-1:0] ec,
                             input logic ev, input logic ew);
        total++;
        if (y !== ey || ch !== ec || valid !== ev || wrap !== ew) begin
            bad++;
            $display("FAIL %s: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
                     tag, y, ch, valid, wrap, ey, ec, ev, ew);
        end
    endtask

    // Monitor: outputs update every edge, so every sampled edge with a pending entry is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_now(e.tag, e.y, e.ch, e.valid, e.wrap);
            end
        end
    end

    localparam logic [CHANNELS*WIDTH-1:0] PLAN = 16'h93A5;

    initial begin
        logic [CHANNELS*WIDTH-1:0] rd;
        rst_n = 1'b0; en_n = 1'b0; mode = 1'b0; sel = '0; data = PLAN;
        #2;
        check_now("reset_before_clk", '0, '0, 1'b0, 1'b0);

        cyc(1'b0, 1'b0, 1'b0, SW'(2), PLAN, "reset_held");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, SW'(1), PLAN, "disabled_hold");

        for (int i = 0; i < CHANNELS; i++) cyc(1'b1, 1'b0, 1'b0, SW'(i), PLAN, "manual_select");

        cyc(1'b1, 1'b0, 1'b0, SW'(2), PLAN, "gate_pre");
        cyc(1'b1, 1'b1, 1'b0, SW'(2), PLAN, "gate_off");
        cyc(1'b1, 1'b1, 1'b0, SW'(0), PLAN, "gate_off_sel_ignored");
        cyc(1'b1, 1'b0, 1'b0, SW'(2), PLAN, "gate_on");

        for (int i = 0; i < 2 * CHANNELS * DWELL + 1; i++)
            cyc(1'b1, 1'b0, 1'b1, SW'(1), PLAN, "scan_sweep");

        cyc(1'b1, 1'b0, 1'b0, SW'(0), PLAN, "scan_exit");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, SW'(1), PLAN, "midscan_run");
        cyc(1'b1, 1'b0, 1'b0, SW'(3), PLAN, "midscan_manual");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, SW'(3), PLAN, "midscan_restart");

        cyc(1'b1, 1'b1, 1'b1, SW'(3), PLAN, "scan_disable");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, SW'(3), PLAN, "scan_reenable");

        // Live data during a dwell must show up on y.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, SW'(0), 16'($urandom), "scan_live_data");

        // Asynchronous reset mid-scan, checked before the next clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_midscan", '0, '0, 1'b0, 1'b0);
        m_ch = 0; m_scan = 0; m_t = 0;
        cyc(1'b0, 1'b0, 1'b1, SW'(2), PLAN, "reset_low");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, SW'(2), PLAN, "post_reset_scan");

        for (int i = 0; i < 600; i++) begin
            rd = 16'($urandom);
            cyc(1'b1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                SW'($urandom_range(0, CHANNELS - 1)), rd, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
